rv_alu_arbiter: RTL and testbench

- Shares one rv_alu instance between two requesters: req0 is the execute stage and req1 is the branch/address-generation unit.
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- Round-robin arbitration; one transaction in flight at a time.
- Operands are registered before the ALU and the result is registered after it, giving a fixed 2-cycle accept-to-response latency.

---
 rtl/rv_alu_arbiter.sv | 113 +++++++++++
 tb/tb_rv_alu_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_alu_arbiter.sv
// rv_alu_arbiter: round-robin sharing of one rv_alu between the execute stage (req0) and branch/AGU (req1).
//   clk, reset_i (async, active-high)
//   reqN_valid_i/reqN_ready_o + reqN_opr_a_i/opr_b_i/op_sel_i/pc_i : request channels
//   alu_opr_a_o/opr_b_o/op_sel_o/pc_o (registered), alu_res_i/alu_zero_i : ALU interface
//   rspN_valid_o/rspN_ready_i + rspN_res_o/rspN_zero_o (registered) : response channels
//   busy_o : a transaction is in flight
module rv_alu_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 64,
  parameter int OP_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset_i,
  input  logic                  req0_valid_i,
  output logic                  req0_ready_o,
  input  logic [DATA_WIDTH-1:0] req0_opr_a_i,
  input  logic [DATA_WIDTH-1:0] req0_opr_b_i,
  input  logic [OP_WIDTH-1:0]   req0_op_sel_i,
  input  logic [ADDR_WIDTH-1:0] req0_pc_i,
  input  logic                  req1_valid_i,
  output logic                  req1_ready_o,
  input  logic [DATA_WIDTH-1:0] req1_opr_a_i,
  input  logic [DATA_WIDTH-1:0] req1_opr_b_i,
  input  logic [OP_WIDTH-1:0]   req1_op_sel_i,
  input  logic [ADDR_WIDTH-1:0] req1_pc_i,
  output logic [DATA_WIDTH-1:0] alu_opr_a_o,
  output logic [DATA_WIDTH-1:0] alu_opr_b_o,
  output logic [OP_WIDTH-1:0]   alu_op_sel_o,
  output logic [ADDR_WIDTH-1:0] alu_pc_o,
  input  logic [DATA_WIDTH-1:0] alu_res_i,
  input  logic                  alu_zero_i,
  output logic                  rsp0_valid_o,
  input  logic                  rsp0_ready_i,
  output logic [DATA_WIDTH-1:0] rsp0_res_o,
  output logic                  rsp0_zero_o,
  output logic                  rsp1_valid_o,
  input  logic                  rsp1_ready_i,
  output logic [DATA_WIDTH-1:0] rsp1_res_o,
  output logic                  rsp1_zero_o,
  output logic                  busy_o
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;
  state_e state_q, state_d;
  logic last_grant_q, last_grant_d, owner_q, owner_d;
  logic [DATA_WIDTH-1:0] opr_a_q, opr_a_d, opr_b_q, opr_b_d;
  logic [OP_WIDTH-1:0] op_sel_q, op_sel_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [1:0] rsp_valid_q, rsp_valid_d, rsp_zero_q, rsp_zero_d;
  logic [DATA_WIDTH-1:0] rsp_res_q [2];
  logic [DATA_WIDTH-1:0] rsp_res_d [2];
  logic hs, win, gnt, acc;
  always_comb begin
    hs = (state_q == RESP) && rsp_valid_q[owner_q] && (owner_q ? rsp1_ready_i : rsp0_ready_i);
    // a response handshake reopens the accept window in the same cycle
    win = (state_q == IDLE) || hs;
    gnt = (req0_valid_i && req1_valid_i) ? ~last_grant_q : req1_valid_i;
    acc = win && (req0_valid_i || req1_valid_i);
    opr_a_d = acc ? (gnt ? req1_opr_a_i : req0_opr_a_i) : opr_a_q;
    opr_b_d = acc ? (gnt ? req1_opr_b_i : req0_opr_b_i) : opr_b_q;
    op_sel_d = acc ? (gnt ? req1_op_sel_i : req0_op_sel_i) : op_sel_q;
    pc_d = acc ? (gnt ? req1_pc_i : req0_pc_i) : pc_q;
    last_grant_d = acc ? gnt : last_grant_q;
    owner_d = acc ? gnt : owner_q;
    rsp_valid_d = rsp_valid_q;
    rsp_zero_d = rsp_zero_q;
    rsp_res_d = rsp_res_q;
    if (state_q == EXEC) begin
      rsp_valid_d[owner_q] = 1'b1;
      rsp_zero_d[owner_q] = alu_zero_i;
      rsp_res_d[owner_q] = alu_res_i;
    end
    if (hs) rsp_valid_d[owner_q] = 1'b0;
    state_d = acc ? EXEC : (state_q == EXEC || (state_q == RESP && !hs)) ? RESP : IDLE;
  end
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      last_grant_q <= 1'b1;
      owner_q <= 1'b0;
      opr_a_q <= '0;
      opr_b_q <= '0;
      op_sel_q <= '0;
      pc_q <= '0;
      rsp_valid_q <= '0;
      rsp_zero_q <= '0;
      rsp_res_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      last_grant_q <= last_grant_d;
      owner_q <= owner_d;
      opr_a_q <= opr_a_d;
      opr_b_q <= opr_b_d;
      op_sel_q <= op_sel_d;
      pc_q <= pc_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_zero_q <= rsp_zero_d;
      rsp_res_q <= rsp_res_d;
    end
  end
  assign req0_ready_o = acc && !gnt;
  assign req1_ready_o = acc && gnt;
  assign alu_opr_a_o = opr_a_q;
  assign alu_opr_b_o = opr_b_q;
  assign alu_op_sel_o = op_sel_q;
  assign alu_pc_o = pc_q;
  assign rsp0_valid_o = rsp_valid_q[0];
  assign rsp1_valid_o = rsp_valid_q[1];
  assign rsp0_zero_o = rsp_zero_q[0];
  assign rsp1_zero_o = rsp_zero_q[1];
  assign rsp0_res_o = rsp_res_q[0];
  assign rsp1_res_o = rsp_res_q[1];
  assign busy_o = state_q != IDLE;
endmodule

// File: tb/tb_rv_alu_arbiter.sv
// tb_rv_alu_arbiter: directed vector bench for rv_alu_arbiter with a small rv_alu model.
module tb_rv_alu_arbiter;
  logic clk = 1'b0;
  logic reset_i;
  logic req0_valid_i, req0_ready_o, req1_valid_i, req1_ready_o;
  logic [63:0] req0_opr_a_i, req0_opr_b_i, req0_pc_i, req1_opr_a_i, req1_opr_b_i, req1_pc_i;
  logic [4:0] req0_op_sel_i, req1_op_sel_i, alu_op_sel_o;
  logic [63:0] alu_opr_a_o, alu_opr_b_o, alu_pc_o, alu_res_i;
  logic alu_zero_i;
  logic rsp0_valid_o, rsp0_ready_i, rsp0_zero_o, rsp1_valid_o, rsp1_ready_i, rsp1_zero_o;
  logic [63:0] rsp0_res_o, rsp1_res_o;
  logic busy_o;
  int n_cmp = 0;
  int n_fail = 0;

  rv_alu_arbiter dut (
    .clk(clk), .reset_i(reset_i),
    .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o), .req0_opr_a_i(req0_opr_a_i),
    .req0_opr_b_i(req0_opr_b_i), .req0_op_sel_i(req0_op_sel_i), .req0_pc_i(req0_pc_i),
    .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o), .req1_opr_a_i(req1_opr_a_i),
    .req1_opr_b_i(req1_opr_b_i), .req1_op_sel_i(req1_op_sel_i), .req1_pc_i(req1_pc_i),
    .alu_opr_a_o(alu_opr_a_o), .alu_opr_b_o(alu_opr_b_o), .alu_op_sel_o(alu_op_sel_o),
    .alu_pc_o(alu_pc_o), .alu_res_i(alu_res_i), .alu_zero_i(alu_zero_i),
    .rsp0_valid_o(rsp0_valid_o), .rsp0_ready_i(rsp0_ready_i), .rsp0_res_o(rsp0_res_o),
    .rsp0_zero_o(rsp0_zero_o), .rsp1_valid_o(rsp1_valid_o), .rsp1_ready_i(rsp1_ready_i),
    .rsp1_res_o(rsp1_res_o), .rsp1_zero_o(rsp1_zero_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  always_comb begin
    alu_res_i = alu_op_sel_o == 5'h00 ? alu_opr_a_o + alu_opr_b_o :
                alu_op_sel_o == 5'h01 ? alu_opr_a_o - alu_opr_b_o :
                alu_op_sel_o == 5'h02 ? alu_opr_a_o ^ alu_opr_b_o :
                alu_op_sel_o == 5'h03 ? alu_opr_a_o | alu_opr_b_o :
                alu_op_sel_o == 5'h04 ? alu_opr_a_o & alu_opr_b_o :
                alu_op_sel_o == 5'h0E ? alu_pc_o + 64'd4 :
                alu_op_sel_o == 5'h10 ? alu_pc_o + (alu_opr_b_o << 12) : 64'd0;
    alu_zero_i = alu_res_i == 64'd0;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic id;
    logic [4:0] op;
    logic [63:0] a, b, pc, exp_res;
  } vec_t;
  vec_t vt [9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic id, input logic v, input logic [4:0] op,
                         input logic [63:0] a, input logic [63:0] b, input logic [63:0] pc);
    if (id) begin
      req1_valid_i = v; req1_op_sel_i = op; req1_opr_a_i = a; req1_opr_b_i = b; req1_pc_i = pc;
    end else begin
      req0_valid_i = v; req0_op_sel_i = op; req0_opr_a_i = a; req0_opr_b_i = b; req0_pc_i = pc;
    end
  endtask

  function automatic logic rdy(input logic id);
    return id ? req1_ready_o : req0_ready_o;
  endfunction
  function automatic logic rval(input logic id);
    return id ? rsp1_valid_o : rsp0_valid_o;
  endfunction
  function automatic logic [63:0] rres(input logic id);
    return id ? rsp1_res_o : rsp0_res_o;
  endfunction
  function automatic logic rzero(input logic id);
    return id ? rsp1_zero_o : rsp0_zero_o;
  endfunction

  logic [63:0] c0, c1, exp_res;
  logic exp_id;

  initial begin
    vt[0] = '{1'b0, 5'h00, 64'd5,    64'd7,    64'h0,    64'd12};
    vt[1] = '{1'b1, 5'h02, 64'hF0,   64'h0F,   64'h0,    64'hFF};
    vt[2] = '{1'b0, 5'h04, 64'hFF,   64'h3C,   64'h0,    64'h3C};
    vt[3] = '{1'b1, 5'h0E, 64'd0,    64'd0,    64'h1000, 64'h1004};
    vt[4] = '{1'b1, 5'h10, 64'd0,    64'd1,    64'h1000, 64'h2000};
    vt[5] = '{1'b0, 5'h11, 64'd3,    64'd4,    64'h40,   64'h0};
    vt[6] = '{1'b0, 5'h01, 64'd10,   64'd3,    64'h0,    64'd7};
    vt[7] = '{1'b1, 5'h03, 64'hA0,   64'h05,   64'h0,    64'hA5};
    vt[8] = '{1'b1, 5'h01, 64'd9,    64'd9,    64'h0,    64'h0};
    reset_i = 1'b1;
    set_req(1'b0, 1'b0, 5'h0, 64'h0, 64'h0, 64'h0);
    set_req(1'b1, 1'b0, 5'h0, 64'h0, 64'h0, 64'h0);
    rsp0_ready_i = 1'b1;
    rsp1_ready_i = 1'b1;
    tick(); tick();
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_rsp_valid", {62'd0, rsp1_valid_o, rsp0_valid_o}, 64'd0);
    check("rst_alu_a", alu_opr_a_o, 64'd0);
    check("rst_rsp0_res", rsp0_res_o, 64'd0);
    reset_i = 1'b0;
    tick();

    // dual request right after reset: req0 first, then req1 after handshake
    set_req(1'b0, 1'b1, 5'h01, 64'd10, 64'd3, 64'h0);
    set_req(1'b1, 1'b1, 5'h02, 64'hF0, 64'h0F, 64'h0);
    #1;
    check("dual_rdy0", 64'(req0_ready_o), 64'd1);
    check("dual_rdy1", 64'(req1_ready_o), 64'd0);
    tick();
    req0_valid_i = 1'b0;
    check("dual_exec_rdy1", 64'(req1_ready_o), 64'd0);
    check("dual_exec_rsp1v", 64'(rsp1_valid_o), 64'd0);
    tick();
    check("dual_rsp0v", 64'(rsp0_valid_o), 64'd1);
    check("dual_rsp0res", rsp0_res_o, 64'd7);
    check("dual_rsp1v_idle", 64'(rsp1_valid_o), 64'd0);
    check("dual_rdy1_hs", 64'(req1_ready_o), 64'd1);
    tick();
    req1_valid_i = 1'b0;
    check("dual_rsp0v_clr", 64'(rsp0_valid_o), 64'd0);
    tick();
    check("dual_rsp1v", 64'(rsp1_valid_o), 64'd1);
    check("dual_rsp1res", rsp1_res_o, 64'hFF);
    tick();
    check("dual_idle", 64'(busy_o), 64'd0);

    // backpressure on rsp0 with req1 waiting
    rsp0_ready_i = 1'b0;
    set_req(1'b0, 1'b1, 5'h00, 64'd1, 64'd2, 64'h0);
    set_req(1'b1, 1'b1, 5'h04, 64'hFF, 64'h3C, 64'h0);
    #1;
    check("bp_rdy0", 64'(req0_ready_o), 64'd1);
    tick();
    req0_valid_i = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      check("bp_rsp0v", 64'(rsp0_valid_o), 64'd1);
      check("bp_rsp0res", rsp0_res_o, 64'd3);
      check("bp_rdy1_blocked", 64'(req1_ready_o), 64'd0);
      check("bp_busy", 64'(busy_o), 64'd1);
      tick();
    end
    rsp0_ready_i = 1'b1;
    #1;
    check("bp_rdy1_release", 64'(req1_ready_o), 64'd1);
    tick();
    req1_valid_i = 1'b0;
    check("bp_rsp0v_clr", 64'(rsp0_valid_o), 64'd0);
    tick();
    check("bp_rsp1res", rsp1_res_o, 64'h3C);
    tick();

    // fairness: both valid continuously, grants alternate starting with req0
    c0 = 64'd1;
    c1 = 64'd2;
    set_req(1'b0, 1'b1, 5'h00, c0, 64'd10, 64'h0);
    set_req(1'b1, 1'b1, 5'h02, c1, 64'hFF, 64'h0);
    #1;
    for (int t = 0; t < 8; t++) begin
      exp_id = t[0];
      check("fair_rdy_win", 64'(rdy(exp_id)), 64'd1);
      check("fair_rdy_lose", 64'(rdy(!exp_id)), 64'd0);
      exp_res = exp_id ? (c1 ^ 64'hFF) : (c0 + 64'd10);
      tick();
      if (exp_id) begin
        c1 = c1 + 64'd3;
        set_req(1'b1, 1'b1, 5'h02, c1, 64'hFF, 64'h0);
      end else begin
        c0 = c0 + 64'd5;
        set_req(1'b0, 1'b1, 5'h00, c0, 64'd10, 64'h0);
      end
      tick();
      check("fair_rspv", 64'(rval(exp_id)), 64'd1);
      check("fair_other_rspv", 64'(rval(!exp_id)), 64'd0);
      check("fair_res", rres(exp_id), exp_res);
    end
    req0_valid_i = 1'b0;
    req1_valid_i = 1'b0;
    tick(); tick();

    // single-requester vectors with fixed 2-cycle latency
    for (int i = 0; i < 9; i++) begin
      set_req(vt[i].id, 1'b1, vt[i].op, vt[i].a, vt[i].b, vt[i].pc);
      #1;
      check($sformatf("vec%0d_rdy", i), 64'(rdy(vt[i].id)), 64'd1);
      check($sformatf("vec%0d_rdy_other", i), 64'(rdy(!vt[i].id)), 64'd0);
      tick();
      req0_valid_i = 1'b0;
      req1_valid_i = 1'b0;
      check($sformatf("vec%0d_busy", i), 64'(busy_o), 64'd1);
      check($sformatf("vec%0d_op", i), 64'(alu_op_sel_o), 64'(vt[i].op));
      check($sformatf("vec%0d_early", i), 64'(rval(vt[i].id)), 64'd0);
      tick();
      check($sformatf("vec%0d_rspv", i), 64'(rval(vt[i].id)), 64'd1);
      check($sformatf("vec%0d_res", i), rres(vt[i].id), vt[i].exp_res);
      check($sformatf("vec%0d_zero", i), 64'(rzero(vt[i].id)), 64'(vt[i].exp_res == 64'd0));
      tick();
      check($sformatf("vec%0d_idle", i), 64'(busy_o), 64'd0);
    end

    // async reset mid-EXEC after a req0 grant, then dual request must go to req0
    set_req(1'b0, 1'b1, 5'h00, 64'd5, 64'd7, 64'h0);
    #1;
    tick();
    req0_valid_i = 1'b0;
    check("mid_busy_pre", 64'(busy_o), 64'd1);
    #2;
    reset_i = 1'b1;
    #1;
    check("mid_busy", 64'(busy_o), 64'd0);
    check("mid_alu_a", alu_opr_a_o, 64'd0);
    check("mid_alu_b", alu_opr_b_o, 64'd0);
    check("mid_rspv", {62'd0, rsp1_valid_o, rsp0_valid_o}, 64'd0);
    tick();
    reset_i = 1'b0;
    set_req(1'b0, 1'b1, 5'h01, 64'd20, 64'd5, 64'h0);
    set_req(1'b1, 1'b1, 5'h00, 64'd1, 64'd1, 64'h0);
    #1;
    check("post_rst_rdy0", 64'(req0_ready_o), 64'd1);
    check("post_rst_rdy1", 64'(req1_ready_o), 64'd0);
    tick();
    req0_valid_i = 1'b0;
    req1_valid_i = 1'b0;
    tick();
    check("post_rst_res", rsp0_res_o, 64'd15);
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
